// File: rtl/wb_regfile_pkg.sv
// ============================================================================
// wb_regfile_pkg : shared FSM state encoding and lane-address helper
// Rev 1.0
// ============================================================================
`default_nettype none

package wb_regfile_pkg;

    localparam int c_cnt_w   = 3;
    localparam int c_max_wait = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } wb_state_t;

    // Number of byte-select address bits below the word index.
    function automatic int lane_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_regfile_slave_if.sv
// ============================================================================
// wb_regfile_slave_if : Wishbone classic slave-side bus bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface wb_regfile_slave_if
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) ();

    logic                  CYC_I;
    logic                  STB_I;
    logic                  WE_I;
    logic                  CAB_I;
    logic [ADDR_W-1:0]     ADR_I;
    logic [DATA_W-1:0]     DAT_I;
    logic [DATA_W/8-1:0]   SEL_I;
    logic [DATA_W-1:0]     DAT_O;
    logic                  ACK_O;
    logic                  ERR_O;
    logic                  RTY_O;

    modport slave (
        input  CYC_I, STB_I, WE_I, CAB_I, ADR_I, DAT_I, SEL_I,
        output DAT_O, ACK_O, ERR_O, RTY_O
    );

    modport master (
        output CYC_I, STB_I, WE_I, CAB_I, ADR_I, DAT_I, SEL_I,
        input  DAT_O, ACK_O, ERR_O, RTY_O
    );

endinterface

`default_nettype wire

// File: rtl/wb_regfile_bank.sv
// ============================================================================
// wb_regfile_bank : RW register array with byte-lane writes and read mux;
//                   top index reads the external status word
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_regfile_bank
    import wb_regfile_pkg::*;
#(
    parameter int              DATA_W   = 32,
    parameter int              NUM_REGS = 8,
    parameter int              IDX_W    = 6,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  wire logic                     i_clk,
    input  wire logic                     i_rst_n,
    input  wire logic                     i_wr_en,
    input  wire logic [IDX_W-1:0]         i_wr_idx,
    input  wire logic [DATA_W-1:0]        i_wr_data,
    input  wire logic [DATA_W/8-1:0]      i_wr_sel,
    input  wire logic [IDX_W-1:0]         i_rd_idx,
    input  wire logic [DATA_W-1:0]        i_sts,
    output logic      [DATA_W-1:0]        o_rd_data,
    output logic      [NUM_REGS*DATA_W-1:0] o_regs
);

    localparam int c_lanes = DATA_W / 8;

    logic [DATA_W-1:0] w_rd_arr [NUM_REGS];

    for (genvar k = 0; k < NUM_REGS - 1; k++) begin : g_reg
        localparam logic [IDX_W-1:0] c_k = IDX_W'(k);
        logic [DATA_W-1:0] r_q;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_q <= RST_VAL;
            end else if (i_wr_en && (i_wr_idx == c_k)) begin
                for (int b = 0; b < c_lanes; b++) begin
                    if (i_wr_sel[b]) begin
                        r_q[b*8 +: 8] <= i_wr_data[b*8 +: 8];
                    end
                end
            end
        end

        assign w_rd_arr[k]                 = r_q;
        assign o_regs[k*DATA_W +: DATA_W]  = r_q;
    end

    // Status slot is not storage: reads see the live status input, the
    // flattened register view shows zero there.
    assign w_rd_arr[NUM_REGS-1]                       = i_sts;
    assign o_regs[(NUM_REGS-1)*DATA_W +: DATA_W]      = '0;

    always_comb begin
        o_rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (i_rd_idx == IDX_W'(k)) begin
                o_rd_data = w_rd_arr[k];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_regfile_slave.sv
// ============================================================================
// wb_regfile_slave : Wishbone classic register-file slave with programmable
//                    wait states, status register and ERR termination
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_regfile_slave
    import wb_regfile_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 8,
    parameter int                NUM_REGS = 8,
    parameter int                WAIT_CYC = 1,
    parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
    input  wire logic                       CLK_I,
    input  wire logic                       RST_I,
    wb_regfile_slave_if.slave               wb,
    input  wire logic [DATA_W-1:0]          sts_i,
    output logic      [NUM_REGS*DATA_W-1:0] regs_o
);

    localparam int c_lb    = lane_bits(DATA_W);
    localparam int c_idx_w = ADDR_W - c_lb;

    localparam logic [c_idx_w:0]   c_num      = (c_idx_w + 1)'(NUM_REGS);
    localparam logic [c_idx_w-1:0] c_sts_idx  = c_idx_w'(NUM_REGS - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'((WAIT_CYC > 0) ? (WAIT_CYC - 1) : 0);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
        $fatal(1, "wb_regfile_slave: DATA_W must be 8, 16, 32 or 64");
    end
    if (ADDR_W <= c_lb || ADDR_W > 31) begin : g_bad_addr_w
        $fatal(1, "wb_regfile_slave: ADDR_W too small for DATA_W or too large");
    end
    if (NUM_REGS < 2 || NUM_REGS > (1 << c_idx_w)) begin : g_bad_num_regs
        $fatal(1, "wb_regfile_slave: NUM_REGS outside 2..2**(ADDR_W-log2(DATA_W/8))");
    end
    if (WAIT_CYC < 0 || WAIT_CYC > c_max_wait) begin : g_bad_wait_cyc
        $fatal(1, "wb_regfile_slave: WAIT_CYC must be 0..7");
    end

    wb_state_t              r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_we;
    logic [c_idx_w-1:0]     r_idx;
    logic [DATA_W-1:0]      r_dat;
    logic [DATA_W/8-1:0]    r_sel;
    logic                   r_resp_err;
    logic [DATA_W-1:0]      r_resp_data;
    logic                   r_ack;
    logic                   r_err;
    logic [DATA_W-1:0]      r_dat_o;

    logic                   w_req;
    logic [c_idx_w-1:0]     w_in_idx;
    logic                   w_in_idle;
    logic [c_idx_w-1:0]     w_cur_idx;
    logic [DATA_W-1:0]      w_cur_dat;
    logic [DATA_W/8-1:0]    w_cur_sel;
    logic                   w_cur_we;
    logic                   w_err;
    logic                   w_enter_resp;
    logic                   w_wr_en;
    logic [DATA_W-1:0]      w_rd_data;
    logic                   w_unused;

    assign w_req     = wb.CYC_I & wb.STB_I;
    assign w_in_idx  = wb.ADR_I[ADDR_W-1:c_lb];
    assign w_in_idle = (r_state == ST_IDLE);

    // With zero wait states the RESP-entry edge is the capture edge itself,
    // so the live bus fields stand in for the not-yet-captured copies.
    assign w_cur_idx = w_in_idle ? w_in_idx  : r_idx;
    assign w_cur_dat = w_in_idle ? wb.DAT_I  : r_dat;
    assign w_cur_sel = w_in_idle ? wb.SEL_I  : r_sel;
    assign w_cur_we  = w_in_idle ? wb.WE_I   : r_we;

    assign w_err = ({1'b0, w_cur_idx} >= c_num) || (w_cur_we && (w_cur_idx == c_sts_idx));

    assign w_enter_resp = w_req && ((w_in_idle && (WAIT_CYC == 0)) ||
                                    ((r_state == ST_WAIT) && (r_cnt == '0)));

    assign w_wr_en = w_enter_resp && w_cur_we && !w_err;

    wb_regfile_bank #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (c_idx_w),
        .RST_VAL  (RST_VAL)
    ) u_bank (
        .i_clk     (CLK_I),
        .i_rst_n   (RST_I),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_cur_idx),
        .i_wr_data (w_cur_dat),
        .i_wr_sel  (w_cur_sel),
        .i_rd_idx  (w_cur_idx),
        .i_sts     (sts_i),
        .o_rd_data (w_rd_data),
        .o_regs    (regs_o)
    );

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_idx       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_resp_err  <= 1'b0;
            r_resp_data <= '0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_dat_o     <= '0;
        end else begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat_o <= '0;

            if (w_enter_resp) begin
                r_resp_err  <= w_err;
                r_resp_data <= (w_cur_we || w_err) ? '0 : w_rd_data;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_we  <= wb.WE_I;
                        r_idx <= w_in_idx;
                        r_dat <= wb.DAT_I;
                        r_sel <= wb.SEL_I;
                        if (WAIT_CYC == 0) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= c_cnt_init;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!w_req) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == '0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                ST_RESP: begin
                    r_ack   <= !r_resp_err;
                    r_err   <= r_resp_err;
                    r_dat_o <= r_resp_data;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wb.ACK_O = r_ack;
    assign wb.ERR_O = r_err;
    assign wb.RTY_O = 1'b0;
    assign wb.DAT_O = r_dat_o;

    assign w_unused = ^{wb.CAB_I, wb.ADR_I};

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile_slave.sv
// ============================================================================
// tb_wb_regfile_slave : directed self-checking bench, one DUT with 1 wait
//                       state / zero reset value and one with 3 / 0xCAFE0001
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_regfile_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [31:0]  sts;
    logic [255:0] regs_a;
    logic [255:0] regs_b;
    logic [255:0] exp_a;

    int checks = 0;
    int errors = 0;

    int          lat;
    logic        ack, err, t2;
    logic [31:0] rd, rd2;

    wb_regfile_slave_if #(.DATA_W(32), .ADDR_W(8)) ifa ();
    wb_regfile_slave_if #(.DATA_W(32), .ADDR_W(8)) ifb ();

    wb_regfile_slave #(
        .DATA_W(32), .ADDR_W(8), .NUM_REGS(8), .WAIT_CYC(1), .RST_VAL(32'h0)
    ) u_dut_a (
        .CLK_I(clk), .RST_I(rst_n), .wb(ifa), .sts_i(sts), .regs_o(regs_a)
    );

    wb_regfile_slave #(
        .DATA_W(32), .ADDR_W(8), .NUM_REGS(8), .WAIT_CYC(3), .RST_VAL(32'hCAFE0001)
    ) u_dut_b (
        .CLK_I(clk), .RST_I(rst_n), .wb(ifb), .sts_i(sts), .regs_o(regs_b)
    );

    task automatic drive_req(input int which, input logic cyc, input logic stb, input logic we,
                             input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        if (which == 0) begin
            ifa.CYC_I = cyc; ifa.STB_I = stb; ifa.WE_I = we;
            ifa.ADR_I = adr; ifa.DAT_I = dat; ifa.SEL_I = sel;
        end else begin
            ifb.CYC_I = cyc; ifb.STB_I = stb; ifb.WE_I = we;
            ifb.ADR_I = adr; ifb.DAT_I = dat; ifb.SEL_I = sel;
        end
    endtask

    // One transfer: latency in edges after the sampling edge (0 = no
    // termination within the budget), termination values, and bus state
    // one cycle later.
    task automatic bus(input int which, input logic we, input logic [7:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel,
                       output int o_lat, output logic o_ack, output logic o_err,
                       output logic [31:0] o_rd, output logic o_t2, output logic [31:0] o_rd2);
        @(negedge clk);
        drive_req(which, 1'b1, 1'b1, we, adr, dat, sel);
        @(posedge clk);
        o_lat = 0; o_ack = 1'b0; o_err = 1'b0; o_rd = '0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (which == 0 ? (ifa.ACK_O | ifa.ERR_O) : (ifb.ACK_O | ifb.ERR_O)) begin
                o_lat = i;
                o_ack = (which == 0) ? ifa.ACK_O : ifb.ACK_O;
                o_err = (which == 0) ? ifa.ERR_O : ifb.ERR_O;
                o_rd  = (which == 0) ? ifa.DAT_O : ifb.DAT_O;
                break;
            end
        end
        drive_req(which, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        @(posedge clk); #1;
        o_t2  = (which == 0) ? (ifa.ACK_O | ifa.ERR_O) : (ifb.ACK_O | ifb.ERR_O);
        o_rd2 = (which == 0) ? ifa.DAT_O : ifb.DAT_O;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sts   = 32'h0;
        ifa.CAB_I = 1'b0; ifb.CAB_I = 1'b0;
        drive_req(0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        drive_req(1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({ifa.ACK_O, ifa.ERR_O, ifa.RTY_O} !== 3'b000) begin errors++; $display("FAIL rst_term got %b exp 000", {ifa.ACK_O, ifa.ERR_O, ifa.RTY_O}); end
        checks++; if (ifa.DAT_O !== 32'h0) begin errors++; $display("FAIL rst_dat got %h exp 00000000", ifa.DAT_O); end
        checks++; if (regs_a !== 256'h0) begin errors++; $display("FAIL rst_regs_a got %h exp 0", regs_a); end
        checks++; if (regs_b !== {32'h0, {7{32'hCAFE0001}}}) begin errors++; $display("FAIL rst_regs_b got %h exp %h", regs_b, {32'h0, {7{32'hCAFE0001}}}); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_a = '0;
        @(posedge clk); #1;
        checks++; if ({ifa.ACK_O, ifa.ERR_O, ifa.RTY_O} !== 3'b000) begin errors++; $display("FAIL idle_term got %b exp 000", {ifa.ACK_O, ifa.ERR_O, ifa.RTY_O}); end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        bus(0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, lat, ack, err, rd, t2, rd2);
        exp_a[63:32] = 32'hDEADBEEF;
        checks++; if (lat !== 2) begin errors++; $display("FAIL wr_lat got %0d exp 2", lat); end
        checks++; if ({ack, err} !== 2'b10) begin errors++; $display("FAIL wr_term got %b exp 10", {ack, err}); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_dat got %h exp 00000000", rd); end
        checks++; if (t2 !== 1'b0) begin errors++; $display("FAIL wr_one_cycle got %b exp 0", t2); end
        checks++; if (regs_a[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_reg1 got %h exp deadbeef", regs_a[63:32]); end
        ifa.CAB_I = 1'b1;
        bus(0, 1'b0, 8'h04, 32'h0, 4'hF, lat, ack, err, rd, t2, rd2);
        ifa.CAB_I = 1'b0;
        checks++; if (lat !== 2) begin errors++; $display("FAIL rd_lat got %0d exp 2", lat); end
        checks++; if ({ack, err} !== 2'b10) begin errors++; $display("FAIL rd_term got %b exp 10", {ack, err}); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_dat got %h exp deadbeef", rd); end
        checks++; if ({t2, rd2} !== 33'h0) begin errors++; $display("FAIL rd_after got %b/%h exp 0/00000000", t2, rd2); end
    endtask

    task automatic test_byte_lanes();
        bus(0, 1'b1, 8'h08, 32'h11223344, 4'h5, lat, ack, err, rd, t2, rd2);
        exp_a[95:64] = 32'h00220044;
        checks++; if ({ack, err} !== 2'b10) begin errors++; $display("FAIL lane_term got %b exp 10", {ack, err}); end
        checks++; if (regs_a[95:64] !== 32'h00220044) begin errors++; $display("FAIL lane_reg2 got %h exp 00220044", regs_a[95:64]); end
        bus(0, 1'b1, 8'h0A, 32'hFFFFFFFF, 4'h0, lat, ack, err, rd, t2, rd2);
        checks++; if ({ack, err} !== 2'b10) begin errors++; $display("FAIL sel0_term got %b exp 10", {ack, err}); end
        checks++; if (regs_a !== exp_a) begin errors++; $display("FAIL sel0_regs got %h exp %h", regs_a, exp_a); end
    endtask

    task automatic test_status();
        sts = 32'hA5A5A5A5;
        bus(0, 1'b0, 8'h1C, 32'h0, 4'hF, lat, ack, err, rd, t2, rd2);
        checks++; if ({ack, err} !== 2'b10) begin errors++; $display("FAIL sts_rd_term got %b exp 10", {ack, err}); end
        checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL sts_rd_dat got %h exp a5a5a5a5", rd); end
        bus(0, 1'b1, 8'h1C, 32'h12345678, 4'hF, lat, ack, err, rd, t2, rd2);
        checks++; if ({ack, err} !== 2'b01) begin errors++; $display("FAIL sts_wr_term got %b exp 01", {ack, err}); end
        checks++; if (regs_a !== exp_a) begin errors++; $display("FAIL sts_wr_regs got %h exp %h", regs_a, exp_a); end
    endtask

    task automatic test_out_of_range();
        bus(0, 1'b0, 8'h20, 32'h0, 4'hF, lat, ack, err, rd, t2, rd2);
        checks++; if (lat !== 2) begin errors++; $display("FAIL oor_rd_lat got %0d exp 2", lat); end
        checks++; if ({ack, err} !== 2'b01) begin errors++; $display("FAIL oor_rd_term got %b exp 01", {ack, err}); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rd_dat got %h exp 00000000", rd); end
        checks++; if (t2 !== 1'b0) begin errors++; $display("FAIL oor_one_cycle got %b exp 0", t2); end
        bus(0, 1'b1, 8'h20, 32'hFFFFFFFF, 4'hF, lat, ack, err, rd, t2, rd2);
        checks++; if ({ack, err} !== 2'b01) begin errors++; $display("FAIL oor_wr_term got %b exp 01", {ack, err}); end
        checks++; if (regs_a !== exp_a) begin errors++; $display("FAIL oor_wr_regs got %h exp %h", regs_a, exp_a); end
        bus(0, 1'b0, 8'hFC, 32'h0, 4'hF, lat, ack, err, rd, t2, rd2);
        checks++; if ({ack, err} !== 2'b01) begin errors++; $display("FAIL oor_top_term got %b exp 01", {ack, err}); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] mask;
        logic       dat_bad;
        mask = '0;
        dat_bad = 1'b0;
        @(negedge clk);
        drive_req(0, 1'b1, 1'b1, 1'b0, 8'h04, 32'h0, 4'hF);
        @(posedge clk);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            mask[i] = ifa.ACK_O;
            if (ifa.ACK_O && ifa.DAT_O !== 32'hDEADBEEF) dat_bad = 1'b1;
        end
        drive_req(0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        @(negedge clk);
        checks++; if (mask !== 9'h124) begin errors++; $display("FAIL b2b_ack_edges got %b exp 100100100", mask); end
        checks++; if (dat_bad !== 1'b0) begin errors++; $display("FAIL b2b_dat got bad exp deadbeef"); end
    endtask

    task automatic test_abort();
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        drive_req(1, 1'b1, 1'b1, 1'b1, 8'h00, 32'h12345678, 4'hF);
        @(posedge clk); #1;
        ifb.STB_I = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ifb.ACK_O | ifb.ERR_O) seen = 1'b1;
        end
        drive_req(1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        @(negedge clk);
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_term got 1 exp 0"); end
        checks++; if (regs_b[31:0] !== 32'hCAFE0001) begin errors++; $display("FAIL abort_reg0 got %h exp cafe0001", regs_b[31:0]); end
        bus(1, 1'b0, 8'h00, 32'h0, 4'hF, lat, ack, err, rd, t2, rd2);
        checks++; if (lat !== 4) begin errors++; $display("FAIL w3_rd_lat got %0d exp 4", lat); end
        checks++; if ({ack, err, rd} !== {2'b10, 32'hCAFE0001}) begin errors++; $display("FAIL w3_rd got %b/%h exp 10/cafe0001", {ack, err}, rd); end
        bus(1, 1'b1, 8'h00, 32'h1111BEEF, 4'h3, lat, ack, err, rd, t2, rd2);
        checks++; if (lat !== 4) begin errors++; $display("FAIL w3_wr_lat got %0d exp 4", lat); end
        checks++; if (regs_b[31:0] !== 32'hCAFEBEEF) begin errors++; $display("FAIL w3_wr_reg0 got %h exp cafebeef", regs_b[31:0]); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        drive_req(0, 1'b1, 1'b1, 1'b1, 8'h0C, 32'h77777777, 4'hF);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        exp_a = '0;
        checks++; if ({ifa.ACK_O, ifa.ERR_O, ifa.DAT_O} !== 34'h0) begin errors++; $display("FAIL mrst_out got %b/%h exp 00/0", {ifa.ACK_O, ifa.ERR_O}, ifa.DAT_O); end
        checks++; if (regs_a !== 256'h0) begin errors++; $display("FAIL mrst_async_regs got %h exp 0", regs_a); end
        drive_req(0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (ifa.ACK_O | ifa.ERR_O) seen = 1'b1;
        end
        @(negedge clk);
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mrst_stale_term got 1 exp 0"); end
        checks++; if (regs_a[127:96] !== 32'h0) begin errors++; $display("FAIL mrst_reg3 got %h exp 00000000", regs_a[127:96]); end
        bus(0, 1'b0, 8'h0C, 32'h0, 4'hF, lat, ack, err, rd, t2, rd2);
        checks++; if ({lat == 2, ack, err, rd} !== {3'b110, 32'h0}) begin errors++; $display("FAIL mrst_rd got lat %0d %b/%h exp lat 2 10/00000000", lat, {ack, err}, rd); end
        bus(0, 1'b0, 8'h04, 32'h0, 4'hF, lat, ack, err, rd, t2, rd2);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mrst_reg1 got %h exp 00000000", rd); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_status();
        test_out_of_range();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
